// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_muldiv_unit                                            |
// | Purpose  : Iterative 32-bit MULT/MULTU/DIV/DIVU sequencer for the EX |
// |            stage. Owns HI/LO and stalls the pipeline while busy.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_MulDivStart,
  input  logic [1:0]  EX_MulDivOp,
  input  logic [31:0] EX_OperandA,
  input  logic [31:0] EX_OperandB,
  input  logic        EX_HIWrite,
  input  logic        EX_LOWrite,
  input  logic        EX_Flush,
  output logic        EX_MulDivStall,
  output logic        EX_MulDivDone,
  output logic [31:0] EX_HI,
  output logic [31:0] EX_LO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;   // operand signs differ
  logic        neg_rem_q, neg_rem_d;   // dividend was negative
  logic        div0_q, div0_d;
  logic [31:0] a_raw_q, a_raw_d;       // dividend as issued, for divide-by-zero HI
  logic [31:0] opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [63:0] acc_q, acc_d;           // {hi_part, lo_part} working register
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Operand conditioning for a new job: signed ops work on magnitudes.
  logic        w_sign_a, w_sign_b;
  logic [31:0] w_mag_a, w_mag_b;

  // One multiply / divide iteration and the final sign fix-up.
  logic [32:0] w_add;
  logic [63:0] w_mul_next;
  logic [32:0] w_shifted;
  logic [32:0] w_diff;
  logic [63:0] w_div_next;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  // Datapath helpers: magnitudes, one iteration step, sign correction.
  always_comb begin
    w_sign_a   = ~EX_MulDivOp[0] & EX_OperandA[31];
    w_sign_b   = ~EX_MulDivOp[0] & EX_OperandB[31];
    w_mag_a    = w_sign_a ? (~EX_OperandA + 32'd1) : EX_OperandA;
    w_mag_b    = w_sign_b ? (~EX_OperandB + 32'd1) : EX_OperandB;

    // Shift-add: low half holds the remaining multiplier bits.
    w_add      = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    w_mul_next = acc_q[0] ? {w_add, acc_q[31:1]}
                          : {1'b0, acc_q[63:32], acc_q[31:1]};

    // Restoring division: high half is the remainder, low half shifts
    // dividend bits out and quotient bits in.
    w_shifted  = {acc_q[63:32], acc_q[31]};
    w_diff     = w_shifted - {1'b0, opnd_q};
    w_div_next = w_diff[32] ? {w_shifted[31:0], acc_q[30:0], 1'b0}
                            : {w_diff[31:0],    acc_q[30:0], 1'b1};

    w_prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    w_quot_fix = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    w_rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  // Next-state and register-update logic for the sequencer.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    a_raw_d   = a_raw_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (EX_MulDivStart && !EX_Flush) begin
          is_div_d  = EX_MulDivOp[1];
          neg_res_d = w_sign_a ^ w_sign_b;
          neg_rem_d = w_sign_a;
          div0_d    = (EX_OperandB == 32'd0);
          a_raw_d   = EX_OperandA;
          opnd_d    = EX_MulDivOp[1] ? w_mag_b : w_mag_a;
          acc_d     = {32'd0, (EX_MulDivOp[1] ? w_mag_a : w_mag_b)};
          count_d   = 5'd31;
          state_d   = S_CALC;
        end else if (!EX_MulDivStart) begin
          if (EX_HIWrite) hi_d = EX_OperandA;
          if (EX_LOWrite) lo_d = EX_OperandA;
        end
      end
      S_CALC: begin
        if (EX_Flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = is_div_q ? w_div_next : w_mul_next;
          count_d = count_q - 5'd1;
          if (count_q == 5'd0) begin
            state_d = S_FIX;
            done_d  = 1'b1;
          end
        end
      end
      S_FIX: begin
        // The instruction owns the stage here, so a flush cannot cancel it.
        if (!is_div_q) begin
          hi_d = w_prod_fix[63:32];
          lo_d = w_prod_fix[31:0];
        end else if (div0_q) begin
          hi_d = a_raw_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = w_rem_fix;
          lo_d = w_quot_fix;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= 5'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      a_raw_q   <= 32'd0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      a_raw_q   <= a_raw_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // Stall is combinational so it freezes the front end in the start cycle.
  always_comb begin
    EX_MulDivStall = ((state_q == S_IDLE) && EX_MulDivStart && !EX_Flush) ||
                     (state_q == S_CALC);
    EX_MulDivDone  = done_q;
    EX_HI          = hi_q;
    EX_LO          = lo_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ex_muldiv_unit                                         |
// | Purpose  : Directed self-checking bench for ex_muldiv_unit.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        hi_wr;
  logic        lo_wr;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_err;

  ex_muldiv_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .EX_MulDivStart (start),
    .EX_MulDivOp    (op),
    .EX_OperandA    (opa),
    .EX_OperandB    (opb),
    .EX_HIWrite     (hi_wr),
    .EX_LOWrite     (lo_wr),
    .EX_Flush       (flush),
    .EX_MulDivStall (stall),
    .EX_MulDivDone  (done),
    .EX_HI          (hi),
    .EX_LO          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a job in the current cycle (T) and follow it to T+34.
  task automatic run_job(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit hold,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int stall_cnt;
    int done_cnt;
    int done_at;
    stall_cnt = 0;
    done_cnt  = 0;
    done_at   = -1;
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    #1;
    for (int k = 0; k <= 33; k++) begin
      if (stall) stall_cnt++;
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      step();
      if (!hold) start = 1'b0;
      #1;
    end
    chk({tag, " stall_cycles"}, 64'(stall_cnt), 64'd33);
    chk({tag, " done_cycle"},   64'(done_at),   64'd33);
    chk({tag, " done_pulses"},  64'(done_cnt),  64'd1);
    chk({tag, " HI"}, {32'd0, hi}, {32'd0, exp_hi});
    chk({tag, " LO"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    int dcnt;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    opa   = 32'd0;
    opb   = 32'd0;
    hi_wr = 1'b0;
    lo_wr = 1'b0;
    flush = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("reset HI",    {32'd0, hi}, 64'd0);
    chk("reset LO",    {32'd0, lo}, 64'd0);
    chk("reset done",  {63'd0, done}, 64'd0);
    chk("reset stall", {63'd0, stall}, 64'd0);

    // MTLO then MTHI
    lo_wr = 1'b1;
    opa   = 32'hCAFE_BABE;
    step();
    lo_wr = 1'b0;
    hi_wr = 1'b1;
    opa   = 32'h1234_5678;
    step();
    hi_wr = 1'b0;
    #1;
    chk("mtlo LO", {32'd0, lo}, 64'h0000_0000_CAFE_BABE);
    chk("mthi HI", {32'd0, hi}, 64'h0000_0000_1234_5678);

    run_job("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_job("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_job("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_job("div_wrap",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,        32'h8000_0000);
    run_job("divu_pos",  2'b11, 32'd100,       32'd7,        1'b0, 32'd2,        32'd14);
    run_job("divu_zero", 2'b11, 32'd100,       32'd0,        1'b0, 32'h0000_0064, 32'hFFFF_FFFF);

    // Flush in IDLE suppresses the start.
    start = 1'b1;
    flush = 1'b1;
    op    = 2'b01;
    opa   = 32'd9;
    opb   = 32'd9;
    #1;
    chk("idle_flush stall", {63'd0, stall}, 64'd0);
    step();
    start = 1'b0;
    flush = 1'b0;
    #1;
    chk("idle_flush no_calc", {63'd0, stall}, 64'd0);

    // Preload HI, then abort a DIVU mid-calculation; the coincident write is ignored.
    hi_wr = 1'b1;
    opa   = 32'h1111_1111;
    step();
    hi_wr = 1'b0;
    start = 1'b1;
    hi_wr = 1'b1;
    op    = 2'b11;
    opa   = 32'd50;
    opb   = 32'd7;
    #1;
    for (int k = 0; k < 10; k++) begin
      step();
      start = 1'b0;
      hi_wr = 1'b0;
      #1;
    end
    flush = 1'b1;
    #1;
    chk("flush T+10 stall", {63'd0, stall}, 64'd1);
    step();
    flush = 1'b0;
    #1;
    chk("flush T+11 stall", {63'd0, stall}, 64'd0);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || stall) dcnt++;
      step();
      #1;
    end
    chk("flush no_done", 64'(dcnt), 64'd0);
    chk("flush HI", {32'd0, hi}, 64'h0000_0000_1111_1111);
    chk("flush LO", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);

    // Start held through FIX, back-to-back second job.
    run_job("b2b_first",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    run_job("b2b_second", 2'b01, 32'd3,         32'd4,         1'b0, 32'd0,         32'd12);

    // Reset in the middle of a MULT.
    start = 1'b1;
    op    = 2'b00;
    opa   = 32'hFFFF_FFFD;
    opb   = 32'd5;
    #1;
    for (int k = 0; k < 20; k++) begin
      step();
      start = 1'b0;
      #1;
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("midreset HI",    {32'd0, hi}, 64'd0);
    chk("midreset LO",    {32'd0, lo}, 64'd0);
    chk("midreset stall", {63'd0, stall}, 64'd0);
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) dcnt++;
      step();
      #1;
    end
    chk("midreset no_done", 64'(dcnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
